// File: rtl/my_sys_avalon_pkg.sv
// Shared types and constants for the my_sys Avalon-MM burst memory slave.
// Holds the bus and memory geometry, the read command payload carried by the
// command FIFO, the write/read engine state enums, the optional stall-LFSR
// constants and small address/burstcount helpers.
package my_sys_avalon_pkg;

  localparam int unsigned ADDR_W            = 32;
  localparam int unsigned DATA_W            = 32;
  localparam int unsigned BURST_W           = 4;
  localparam int unsigned MEM_WORDS         = 256;
  localparam int unsigned READ_LATENCY      = 2;
  localparam int unsigned MAX_PENDING_READS = 4;

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1: feedback from bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [BURST_W-1:0] cnt_t;

  typedef struct packed {
    idx_t idx;
    cnt_t count;
  } rd_cmd_t;

  typedef enum logic {W_IDLE, W_BURST} w_state_t;
  typedef enum logic {R_IDLE, R_BURST} r_state_t;

  // A zero burstcount is treated as a single beat
  function automatic cnt_t norm_count(input cnt_t c);
    return (c == '0) ? cnt_t'(1) : c;
  endfunction

endpackage

// File: rtl/my_sys_mm_slave_mem_if.sv
// Avalon-MM slave bus bundle between the master BFM and my_sys_mm_slave_mem.
// master: drives address/burstcount/writedata/byteenable/write/read.
// slave : drives waitrequest/readdata/readdatavalid.
interface my_sys_mm_slave_mem_if;
  import my_sys_avalon_pkg::*;

  logic [ADDR_W-1:0]  avs_address;
  logic [BURST_W-1:0] avs_burstcount;
  logic [DATA_W-1:0]  avs_writedata;
  logic [BE_W-1:0]    avs_byteenable;
  logic               avs_write;
  logic               avs_read;
  logic               avs_waitrequest;
  logic [DATA_W-1:0]  avs_readdata;
  logic               avs_readdatavalid;

  modport slave (
    input  avs_address, avs_burstcount, avs_writedata, avs_byteenable,
           avs_write, avs_read,
    output avs_waitrequest, avs_readdata, avs_readdatavalid
  );

  modport master (
    output avs_address, avs_burstcount, avs_writedata, avs_byteenable,
           avs_write, avs_read,
    input  avs_waitrequest, avs_readdata, avs_readdatavalid
  );
endinterface

// File: rtl/my_sys_mm_slave_cmd_fifo.sv
// Synchronous FIFO of pending read burst commands (rd_cmd_t).
// Ports: clk, reset (async active-high), push/wdata, pop/rdata (head, show-ahead),
// full/empty flags decoded from the registered occupancy count.
module my_sys_mm_slave_cmd_fifo
  import my_sys_avalon_pkg::*;
#(
  parameter int unsigned DEPTH = MAX_PENDING_READS
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  rd_cmd_t wdata,
  input  logic    pop,
  output rd_cmd_t rdata,
  output logic    full,
  output logic    empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  rd_cmd_t            mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage needs no reset; only pointers and count define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy tracking; DEPTH is a power of 2 so pointers wrap naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/my_sys_mm_slave_mem.sv
// Avalon-MM burst-capable memory slave with pipelined reads.
// Ports: clk, reset (async active-high), avs (my_sys_mm_slave_mem_if.slave bus),
// err_protocol (sticky: read and write asserted in the same cycle).
// Optional build macro MY_SYS_MM_SLAVE_RANDOM_WAIT_EN adds LFSR-driven random
// waitrequest stalls on both reads and writes.
module my_sys_mm_slave_mem
  import my_sys_avalon_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  my_sys_mm_slave_mem_if.slave    avs,
  output logic                    err_protocol
);

  logic       rand_stall_c;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop_c;
  rd_cmd_t    head_cmd;
  rd_cmd_t    push_cmd_c;
  logic       accept_w_c;
  logic       accept_r_c;
  idx_t       addr_idx_c;
  logic       unused_addr_c;

  w_state_t   w_state, w_state_n;
  idx_t       w_idx, w_idx_n;
  cnt_t       w_rem, w_rem_n;
  logic       ram_we_c;
  idx_t       ram_widx_c;

  r_state_t   r_state, r_state_n;
  idx_t       r_idx, r_idx_n;
  cnt_t       r_rem, r_rem_n;
  logic       issue_c;
  idx_t       issue_idx_c;

  logic [DATA_W-1:0]       mem [MEM_WORDS];
  logic [READ_LATENCY-1:0] pipe_vld;
  logic [DATA_W-1:0]       pipe_dat [READ_LATENCY];

`ifdef MY_SYS_MM_SLAVE_RANDOM_WAIT_EN
  logic [15:0] lfsr;

  // Free-running stall generator
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  assign rand_stall_c = (lfsr[1:0] == 2'b00);
`else
  assign rand_stall_c = 1'b0;
`endif

  // Reads stall on a full command FIFO or during a write burst; writes only on random stall
  assign avs.avs_waitrequest = reset | rand_stall_c |
                               (avs.avs_read & (fifo_full | (w_state == W_BURST)));

  assign addr_idx_c    = avs.avs_address[IDX_W+1:2];
  assign unused_addr_c = ^{avs.avs_address[ADDR_W-1:IDX_W+2], avs.avs_address[1:0]};
  assign accept_w_c    = avs.avs_write & ~avs.avs_waitrequest;
  assign accept_r_c    = avs.avs_read & ~avs.avs_write & ~avs.avs_waitrequest;
  assign push_cmd_c    = '{idx: addr_idx_c, count: norm_count(avs.avs_burstcount)};

  // Sticky protocol error; write has priority so the read is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               err_protocol <= 1'b0;
    else if (avs.avs_read && avs.avs_write)  err_protocol <= 1'b1;
  end

  my_sys_mm_slave_cmd_fifo #(.DEPTH(MAX_PENDING_READS)) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept_r_c),
    .wdata (push_cmd_c),
    .pop   (fifo_pop_c),
    .rdata (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Write engine state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state <= W_IDLE;
      w_idx   <= '0;
      w_rem   <= '0;
    end else begin
      w_state <= w_state_n;
      w_idx   <= w_idx_n;
      w_rem   <= w_rem_n;
    end
  end

  // Write engine: first beat latches address/count, later beats walk the burst
  always_comb begin
    w_state_n  = w_state;
    w_idx_n    = w_idx;
    w_rem_n    = w_rem;
    ram_we_c   = 1'b0;
    ram_widx_c = w_idx;
    case (w_state)
      W_IDLE: begin
        if (accept_w_c) begin
          ram_we_c   = 1'b1;
          ram_widx_c = addr_idx_c;
          w_idx_n    = addr_idx_c + IDX_W'(1);
          w_rem_n    = push_cmd_c.count - BURST_W'(1);
          if (push_cmd_c.count > BURST_W'(1)) w_state_n = W_BURST;
        end
      end
      W_BURST: begin
        if (accept_w_c) begin
          ram_we_c = 1'b1;
          w_idx_n  = w_idx + IDX_W'(1);
          w_rem_n  = w_rem - BURST_W'(1);
          if (w_rem == BURST_W'(1)) w_state_n = W_IDLE;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  // Byte-lane RAM write; contents survive reset
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < BE_W; b++) begin
      if (ram_we_c && avs.avs_byteenable[b]) mem[ram_widx_c][8*b +: 8] <= avs.avs_writedata[8*b +: 8];
    end
  end

  // Read engine state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= R_IDLE;
      r_idx   <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= r_state_n;
      r_idx   <= r_idx_n;
      r_rem   <= r_rem_n;
    end
  end

  // Read engine: idle issues the head's first beat directly; the last beat of a
  // burst pops the next command so back-to-back bursts have no bubble
  always_comb begin
    r_state_n   = r_state;
    r_idx_n     = r_idx;
    r_rem_n     = r_rem;
    fifo_pop_c  = 1'b0;
    issue_c     = 1'b0;
    issue_idx_c = r_idx;
    case (r_state)
      R_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop_c  = 1'b1;
          issue_c     = 1'b1;
          issue_idx_c = head_cmd.idx;
          r_idx_n     = head_cmd.idx + IDX_W'(1);
          r_rem_n     = head_cmd.count - BURST_W'(1);
          if (head_cmd.count > BURST_W'(1)) r_state_n = R_BURST;
        end
      end
      R_BURST: begin
        issue_c = 1'b1;
        r_idx_n = r_idx + IDX_W'(1);
        r_rem_n = r_rem - BURST_W'(1);
        if (r_rem == BURST_W'(1)) begin
          if (!fifo_empty) begin
            fifo_pop_c = 1'b1;
            r_idx_n    = head_cmd.idx;
            r_rem_n    = head_cmd.count;
          end else begin
            r_state_n = R_IDLE;
          end
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  // Read latency pipe; stage 0 samples RAM before any same-cycle write lands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_vld <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) pipe_dat[i] <= '0;
    end else begin
      pipe_vld[0] <= issue_c;
      pipe_dat[0] <= mem[issue_idx_c];
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
      end
    end
  end

  assign avs.avs_readdatavalid = pipe_vld[READ_LATENCY-1];
  assign avs.avs_readdata      = pipe_dat[READ_LATENCY-1];

endmodule
